// File: rtl/sync_fifo_flex_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : sync_fifo_flex_if                                    |
// | Description : Write/read handshake, data and status bundle for     |
// |               sync_fifo_flex. master = producer/consumer side,     |
// |               slave = FIFO side.                                   |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
interface sync_fifo_flex_if #(
   parameter int ASIZE = 4,
   parameter int DSIZE = 8
);
   logic             flush;
   logic             wr_en;
   logic [DSIZE-1:0] din;
   logic             rd_en;
   logic [DSIZE-1:0] dout;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [ASIZE:0]   count;
   logic             overflow;
   logic             underflow;

   modport master (
      output flush, wr_en, din, rd_en,
      input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  flush, wr_en, din, rd_en,
      output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_flex.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : sync_fifo_flex                                       |
// | Description : Single-clock FIFO with optional first-word-fall-     |
// |               through read, almost-full/empty thresholds, count,   |
// |               synchronous flush and sticky overflow/underflow.     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module sync_fifo_flex #(
   parameter int ASIZE     = 4,
   parameter int DSIZE     = 8,
   parameter int FWFT      = 0,
   parameter int AF_THRESH = 2**ASIZE - 2,
   parameter int AE_THRESH = 2
) (
   input  wire logic         clk,
   input  wire logic         rstn,
   sync_fifo_flex_if.slave   bus
);
   localparam int             DEPTH   = 2**ASIZE;
   localparam logic [ASIZE:0] DEPTH_C = (ASIZE+1)'(DEPTH);
   localparam logic [ASIZE:0] AF_C    = (ASIZE+1)'(AF_THRESH);
   localparam logic [ASIZE:0] AE_C    = (ASIZE+1)'(AE_THRESH);
   localparam logic [ASIZE:0] ONE_C   = (ASIZE+1)'(1);

   logic [DSIZE-1:0] mem [DEPTH];
   logic [ASIZE:0]   wr_ptr;
   logic [ASIZE:0]   rd_ptr;
   logic [ASIZE:0]   cnt;
   logic             ovf;
   logic             unf;
   logic             is_full;
   logic             is_empty;
   logic             wr_acc;
   logic             rd_acc;

   // Status flags decode only the count register, never the requests
   assign is_full          = (cnt == DEPTH_C);
   assign is_empty         = (cnt == '0);
   assign bus.full         = is_full;
   assign bus.empty        = is_empty;
   assign bus.almost_full  = (cnt >= AF_C);
   assign bus.almost_empty = (cnt <= AE_C);
   assign bus.count        = cnt;
   assign bus.overflow     = ovf;
   assign bus.underflow    = unf;

   // A request is honoured only against the flags held at the start of the cycle
   assign wr_acc = bus.wr_en && !is_full;
   assign rd_acc = bus.rd_en && !is_empty;

   // Pointers, occupancy and sticky error flags; flush beats any request
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
         unf    <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
         unf    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + ONE_C;
         if (rd_acc) rd_ptr <= rd_ptr + ONE_C;
         case ({wr_acc, rd_acc})
            2'b10:   cnt <= cnt + ONE_C;
            2'b01:   cnt <= cnt - ONE_C;
            default: cnt <= cnt;
         endcase
         if (bus.wr_en && is_full)  ovf <= 1'b1;
         if (bus.rd_en && is_empty) unf <= 1'b1;
      end
   end

   // Storage array; contents are deliberately left unreset
   always_ff @(posedge clk) begin
      if (wr_acc && !bus.flush) mem[wr_ptr[ASIZE-1:0]] <= bus.din;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is always presented; meaningful only while not empty
         assign bus.dout = mem[rd_ptr[ASIZE-1:0]];
      end else begin : g_std
         // Registered read port: loads the head word on an accepted read
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)            bus.dout <= '0;
            else if (bus.flush)   bus.dout <= '0;
            else if (rd_acc)      bus.dout <= mem[rd_ptr[ASIZE-1:0]];
         end
      end
   endgenerate
endmodule
`default_nettype wire
